hazard_ctrl_unit: RTL and testbench
===================================

// Module: hazard_ctrl_unit
// PURPOSE
//  Parametrised hazard and exception controller for the in-order 16-bit pipeline.
//  Sits beside the IF/ID and ID/EX registers and drives PC enable, IF/ID write, ID/EX bubble, flush and PC-select.
//  Adds over the combinational hazard logic: multi-cycle load-use stalls, registered sticky exception cause, one-cycle flush/redirect FSM, and generic-width overflow check.
// PARAMETERS
//  DATA_W      16       datapath width; overflow check is on bit DATA_W-1
//  REG_AW      4        register-address width
//  OPC_W       4        opcode width
//  LOAD_LAT    1        load-use stall cycles, 1..7
//  ILLEGAL_MSK 16'h4308 bit n set => opcode n illegal (2**OPC_W bits)
// PORTS
//  clk             in  1       clock
//  rst_n           in  1       asynchronous active-low reset
//  id_opcode       in  OPC_W   opcode in ID
//  if_id_rs/rt     in  REG_AW  ID source registers
//  id_ex_rt        in  REG_AW  EX destination
//  ex_mem_rt       in  REG_AW  MEM destination
//  id_ex_memread   in  1       EX instruction is a load
//  id_ex_regwrite  in  1       EX writes a register
//  ex_mem_regwrite in  1       MEM writes a register
//  br_eq, br_lt    in  1       ID comparator results
//  ex_ovf_chk      in  1       EX instruction is signed add/sub
//  ex_op1, ex_op2  in  DATA_W  EX ALU operands (op2 already inverted for sub)
//  ex_result       in  DATA_W  EX ALU result
//  exc_ack         in  1       handler acknowledges exception
//  pc_enable       out 1       PC may update
//  if_id_write     out 1       IF/ID may load
//  id_ex_bubble    out 1       insert NOP into ID/EX
//  flush_sel       out 2       00 none, 01 IF/ID, 10 IF/ID+ID/EX+EX/MEM
//  pc_sel          out 2       00 PC+1, 01 branch/jump target, 10 exception vector
//  exc_valid       out 1       registered; exception pending
//  exc_cause       out 2       registered; 00 none, 01 illegal opcode, 10 overflow
//  exc_lost        out 1       registered; sticky, second exception while pending
// BEHAVIOUR
//  - Control outputs are combinational from state+inputs; exc_* are registered. States RUN, LD_WAIT, EXC_FLUSH.
//  - Reset (async, any state): state=RUN, counter=0, exc_valid=0, exc_cause=00, exc_lost=0; while rst_n=0: pc_enable=0, if_id_write=0, id_ex_bubble=1, flush_sel=00, pc_sel=00.
//  - Priority in RUN, highest first: overflow > illegal > load-use > branch-operand > taken branch/jump > normal.
//  - Overflow: ex_ovf_chk & (op1[MSB]==op2[MSB]) & (result[MSB]!=op1[MSB]) -> cause 10, go EXC_FLUSH.
//  - Illegal: ILLEGAL_MSK[id_opcode] -> cause 01, go EXC_FLUSH.
//  - EXC_FLUSH (1 cycle): flush_sel=10, pc_sel=10, pc_enable=1, bubble=1; -> RUN. exc_valid set on entry.
//  - Exception while exc_valid=1: cause unchanged, exc_lost<=1; flush/redirect still performed.
//  - exc_ack with exc_valid: clear exc_valid/exc_cause next edge; same-cycle new exception wins (reloads cause, exc_lost unchanged).
//  - Load-use: id_ex_memread & id_ex_rt matches rs or rt -> pc_enable=0, if_id_write=0, bubble=1 this cycle;
//    if LOAD_LAT>1 go LD_WAIT with count LOAD_LAT-1, hold same outputs, decrement, return to RUN at 0.
//  - Branch-operand (beq 6, blt 5, bgt 4): rs/rt matches id_ex_rt & id_ex_regwrite, or ex_mem_rt & ex_mem_regwrite -> stall as load-use, one cycle, re-evaluated.
//  - Taken: j(7) | beq&br_eq | blt&br_lt | bgt&!br_lt&!br_eq -> pc_sel=01, flush_sel=01.
//  - Normal: pc_enable=1, if_id_write=1, bubble=0, flush_sel=00, pc_sel=00.
//  - Register $0 compares as a real match (no zero-register exemption).
// CONFIGURATION
//  HCU_BR_FWD_EN defined: EX/MEM-to-ID branch forwarding exists; only the ID/EX dependency stalls a branch.
//  Undefined: both ID/EX and EX/MEM dependencies stall as above.
// STRUCTURE
//  hcu_pkg: opcode localparams (J, BEQ, BLT, BGT), cause, flush_sel and pc_sel encodings, state enum.
//  Sub-module hcu_ovf_detect (DATA_W-parametrised, combinational) computes the overflow flag.
// TESTING
//  - Load r3 in EX, ID add uses r3, LOAD_LAT=3 -> pc_enable=0, bubble=1 for exactly 3 cycles, then normal.
//  - ex_op1=16'h7FFF, ex_op2=16'h0001, result=16'h8000, ex_ovf_chk=1 -> flush_sel=10, pc_sel=10 one cycle; exc_cause=10 next edge.
//  - id_opcode=4'h9 -> cause 01; second illegal before exc_ack -> cause stays 01, exc_lost=1.
//  - beq rs=r2, id_ex_rt=r2, id_ex_regwrite=1 -> 1-cycle stall; with ex_mem_rt=r2 only: stall unless HCU_BR_FWD_EN.
//  - blt with br_lt=1, no hazards -> pc_sel=01, flush_sel=01, pc_enable=1.
//  - rst_n low mid-LD_WAIT -> outputs at reset values immediately; after release, state RUN, no residual stall.

Source files
------------

// File: rtl/hcu_pkg.sv
// Shared encodings for the hazard/exception controller: opcodes, exception causes,
// flush and PC-select codes, and the controller state enum.
package hcu_pkg;

  localparam int OPC_J   = 7;
  localparam int OPC_BEQ = 6;
  localparam int OPC_BLT = 5;
  localparam int OPC_BGT = 4;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_OVF     = 2'b10;

  localparam logic [1:0] FLUSH_NONE  = 2'b00;
  localparam logic [1:0] FLUSH_IFID  = 2'b01;
  localparam logic [1:0] FLUSH_ALL   = 2'b10;

  localparam logic [1:0] PCSEL_SEQ    = 2'b00;
  localparam logic [1:0] PCSEL_TARGET = 2'b01;
  localparam logic [1:0] PCSEL_EXC    = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN       = 2'b00,
    ST_LD_WAIT   = 2'b01,
    ST_EXC_FLUSH = 2'b10
  } hcu_state_e;

endpackage

// File: rtl/hcu_ovf_detect.sv
// Signed add/sub overflow flag: operands share a sign and the result's sign differs.
module hcu_ovf_detect #(
  parameter int DATA_W = 16
) (
  input  logic signed [DATA_W-1:0] op1,
  input  logic signed [DATA_W-1:0] op2,
  input  logic signed [DATA_W-1:0] result,
  input  logic                     chk,
  output logic                     ovf
);

  assign ovf = chk & (op1[DATA_W-1] == op2[DATA_W-1]) & (result[DATA_W-1] != op1[DATA_W-1]);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard and exception controller for the in-order pipeline: load-use/branch stalls,
// exception flush/redirect and sticky cause. Define HCU_BR_FWD_EN when EX/MEM-to-ID branch forwarding exists.
module hazard_ctrl_unit
  import hcu_pkg::*;
#(
  parameter int                    DATA_W      = 16,
  parameter int                    REG_AW      = 4,
  parameter int                    OPC_W       = 4,
  parameter int                    LOAD_LAT    = 1,
  parameter logic [2**OPC_W-1:0]   ILLEGAL_MSK = 16'h4308
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [OPC_W-1:0]         id_opcode,
  input  logic [REG_AW-1:0]        if_id_rs,
  input  logic [REG_AW-1:0]        if_id_rt,
  input  logic [REG_AW-1:0]        id_ex_rt,
  input  logic [REG_AW-1:0]        ex_mem_rt,
  input  logic                     id_ex_memread,
  input  logic                     id_ex_regwrite,
  input  logic                     ex_mem_regwrite,
  input  logic                     br_eq,
  input  logic                     br_lt,
  input  logic                     ex_ovf_chk,
  input  logic signed [DATA_W-1:0] ex_op1,
  input  logic signed [DATA_W-1:0] ex_op2,
  input  logic signed [DATA_W-1:0] ex_result,
  input  logic                     exc_ack,
  output logic                     pc_enable,
  output logic                     if_id_write,
  output logic                     id_ex_bubble,
  output logic [1:0]               flush_sel,
  output logic [1:0]               pc_sel,
  output logic                     exc_valid,
  output logic [1:0]               exc_cause,
  output logic                     exc_lost
);

  hcu_state_e state_q, state_nxt;
  logic [2:0] cnt_q;

  logic ovf, illegal, exc_det, load_use, is_branch, br_dep_ex, br_dep_mem, br_haz, taken;
  logic [1:0] new_cause;

  hcu_ovf_detect #(.DATA_W(DATA_W)) u_ovf (
    .op1    (ex_op1),
    .op2    (ex_op2),
    .result (ex_result),
    .chk    (ex_ovf_chk),
    .ovf    (ovf)
  );

  assign illegal   = ILLEGAL_MSK[id_opcode];
  assign exc_det   = (state_q == ST_RUN) & (ovf | illegal);
  assign new_cause = ovf ? CAUSE_OVF : CAUSE_ILLEGAL;

  // Register $0 is deliberately treated like any other register here.
  assign load_use  = id_ex_memread & ((id_ex_rt == if_id_rs) | (id_ex_rt == if_id_rt));
  assign is_branch = (id_opcode == OPC_W'(OPC_BEQ)) | (id_opcode == OPC_W'(OPC_BLT)) |
                     (id_opcode == OPC_W'(OPC_BGT));
  assign br_dep_ex  = id_ex_regwrite  & ((id_ex_rt  == if_id_rs) | (id_ex_rt  == if_id_rt));
  assign br_dep_mem = ex_mem_regwrite & ((ex_mem_rt == if_id_rs) | (ex_mem_rt == if_id_rt));
`ifdef HCU_BR_FWD_EN
  assign br_haz = is_branch & br_dep_ex;
`else
  assign br_haz = is_branch & (br_dep_ex | br_dep_mem);
`endif

  assign taken = (id_opcode == OPC_W'(OPC_J)) |
                 ((id_opcode == OPC_W'(OPC_BEQ)) & br_eq) |
                 ((id_opcode == OPC_W'(OPC_BLT)) & br_lt) |
                 ((id_opcode == OPC_W'(OPC_BGT)) & ~br_lt & ~br_eq);

  // State register and load-use wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_nxt;
      if (state_q == ST_RUN && !exc_det && load_use)
        cnt_q <= 3'(LOAD_LAT - 1);
      else if (state_q == ST_LD_WAIT)
        cnt_q <= cnt_q - 3'd1;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_RUN: begin
        if (exc_det)
          state_nxt = ST_EXC_FLUSH;
        else if (load_use && LOAD_LAT > 1)
          state_nxt = ST_LD_WAIT;
      end
      ST_LD_WAIT:   if (cnt_q <= 3'd1) state_nxt = ST_RUN;
      ST_EXC_FLUSH: state_nxt = ST_RUN;
      default:      state_nxt = ST_RUN;
    endcase
  end

  // The detecting cycle lets the pipeline advance; the flush in EXC_FLUSH kills the faulting work.
  always_comb begin
    pc_enable    = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    flush_sel    = FLUSH_NONE;
    pc_sel       = PCSEL_SEQ;
    if (!rst_n) begin
      pc_enable    = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (exc_det) begin
            pc_enable = 1'b1;
          end else if (load_use || br_haz) begin
            pc_enable    = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (taken) begin
            flush_sel = FLUSH_IFID;
            pc_sel    = PCSEL_TARGET;
          end
        end
        ST_LD_WAIT: begin
          pc_enable    = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
        ST_EXC_FLUSH: begin
          id_ex_bubble = 1'b1;
          flush_sel    = FLUSH_ALL;
          pc_sel       = PCSEL_EXC;
        end
        default: ;
      endcase
    end
  end

  // Exception status: a new exception outranks a same-cycle acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_valid <= 1'b0;
      exc_cause <= CAUSE_NONE;
      exc_lost  <= 1'b0;
    end else if (exc_det) begin
      if (exc_valid && !exc_ack) begin
        exc_lost <= 1'b1;
      end else begin
        exc_valid <= 1'b1;
        exc_cause <= new_cause;
      end
    end else if (exc_ack && exc_valid) begin
      exc_valid <= 1'b0;
      exc_cause <= CAUSE_NONE;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit (LOAD_LAT=3, default illegal mask).
module tb_hazard_ctrl_unit;

  logic              clk;
  logic              rst_n;
  logic [3:0]        id_opcode;
  logic [3:0]        if_id_rs, if_id_rt, id_ex_rt, ex_mem_rt;
  logic              id_ex_memread, id_ex_regwrite, ex_mem_regwrite;
  logic              br_eq, br_lt, ex_ovf_chk, exc_ack;
  logic signed [15:0] ex_op1, ex_op2, ex_result;
  logic              pc_enable, if_id_write, id_ex_bubble;
  logic [1:0]        flush_sel, pc_sel, exc_cause;
  logic              exc_valid, exc_lost;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] C_NORM  = 7'b110_00_00;
  localparam logic [6:0] C_STALL = 7'b001_00_00;
  localparam logic [6:0] C_TAKEN = 7'b110_01_01;
  localparam logic [6:0] C_FLUSH = 7'b111_10_10;
  localparam logic [6:0] C_RST   = 7'b001_00_00;

  logic [6:0] ctrl;
  logic [3:0] exc;
  assign ctrl = {pc_enable, if_id_write, id_ex_bubble, flush_sel, pc_sel};
  assign exc  = {exc_valid, exc_cause, exc_lost};

  hazard_ctrl_unit #(.DATA_W(16), .REG_AW(4), .OPC_W(4), .LOAD_LAT(3)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_opcode       (id_opcode),
    .if_id_rs        (if_id_rs),
    .if_id_rt        (if_id_rt),
    .id_ex_rt        (id_ex_rt),
    .ex_mem_rt       (ex_mem_rt),
    .id_ex_memread   (id_ex_memread),
    .id_ex_regwrite  (id_ex_regwrite),
    .ex_mem_regwrite (ex_mem_regwrite),
    .br_eq           (br_eq),
    .br_lt           (br_lt),
    .ex_ovf_chk      (ex_ovf_chk),
    .ex_op1          (ex_op1),
    .ex_op2          (ex_op2),
    .ex_result       (ex_result),
    .exc_ack         (exc_ack),
    .pc_enable       (pc_enable),
    .if_id_write     (if_id_write),
    .id_ex_bubble    (id_ex_bubble),
    .flush_sel       (flush_sel),
    .pc_sel          (pc_sel),
    .exc_valid       (exc_valid),
    .exc_cause       (exc_cause),
    .exc_lost        (exc_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_opcode = 4'h0; if_id_rs = 4'd1; if_id_rt = 4'd2; id_ex_rt = 4'd10; ex_mem_rt = 4'd11;
    id_ex_memread = 0; id_ex_regwrite = 0; ex_mem_regwrite = 0;
    br_eq = 0; br_lt = 0; ex_ovf_chk = 0; exc_ack = 0;
    ex_op1 = '0; ex_op2 = '0; ex_result = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #1;
    chk("reset_ctrl", ctrl, C_RST);
    chk("reset_exc", {3'b0, exc}, 7'b0);
    #11 rst_n = 1'b1;
    tick();
    chk("normal", ctrl, C_NORM);

    // Load-use on r3 stalls exactly LOAD_LAT=3 cycles
    id_ex_memread = 1; id_ex_rt = 4'd3; if_id_rs = 4'd3; #1;
    chk("ldu_c1", ctrl, C_STALL);
    tick(); id_ex_memread = 0; #1;
    chk("ldu_c2", ctrl, C_STALL);
    tick();
    chk("ldu_c3", ctrl, C_STALL);
    tick();
    chk("ldu_done", ctrl, C_NORM);
    idle();

    // Positive overflow
    ex_ovf_chk = 1; ex_op1 = 16'sh7FFF; ex_op2 = 16'sh0001; ex_result = 16'sh8000; #1;
    chk("ovf_detect", ctrl, C_NORM);
    tick(); idle(); #1;
    chk("ovf_flush", ctrl, C_FLUSH);
    chk("ovf_cause", {3'b0, exc}, {3'b0, 1'b1, 2'b10, 1'b0});
    tick();
    chk("ovf_after", ctrl, C_NORM);
    exc_ack = 1;
    tick(); exc_ack = 0; #1;
    chk("ovf_acked", {3'b0, exc}, 7'b0);

    // Same-sign-free operands: no overflow
    ex_ovf_chk = 1; ex_op1 = 16'sh7FFF; ex_op2 = -16'sd1; ex_result = 16'sh7FFE;
    tick(); idle(); #1;
    chk("no_ovf", ctrl, C_NORM);
    chk("no_ovf_exc", {3'b0, exc}, 7'b0);

    // Illegal opcode, then a second one before acknowledge
    id_opcode = 4'h9;
    tick(); idle(); #1;
    chk("ill_flush", ctrl, C_FLUSH);
    chk("ill_cause", {3'b0, exc}, {3'b0, 1'b1, 2'b01, 1'b0});
    tick(); id_opcode = 4'h9;
    tick(); idle(); #1;
    chk("ill2_flush", ctrl, C_FLUSH);
    chk("ill2_lost", {3'b0, exc}, {3'b0, 1'b1, 2'b01, 1'b1});

    // Ack together with a negative overflow: new cause wins, lost stays set
    tick();
    exc_ack = 1; ex_ovf_chk = 1; ex_op1 = 16'sh8000; ex_op2 = 16'sh8000; ex_result = 16'sh0000;
    tick(); idle(); #1;
    chk("ack_race", {3'b0, exc}, {3'b0, 1'b1, 2'b10, 1'b1});
    tick(); exc_ack = 1;
    tick(); exc_ack = 0; #1;
    chk("ack_clear", {3'b0, exc}, {3'b0, 1'b0, 2'b00, 1'b1});

    // Branch operand hazards
    id_opcode = 4'd6; if_id_rs = 4'd2; if_id_rt = 4'd5; id_ex_rt = 4'd2; id_ex_regwrite = 1; ex_mem_rt = 4'd9; #1;
    chk("br_idex", ctrl, C_STALL);
    tick(); id_ex_regwrite = 0; #1;
    chk("br_resolved", ctrl, C_NORM);
    ex_mem_rt = 4'd2; ex_mem_regwrite = 1; #1;
`ifdef HCU_BR_FWD_EN
    chk("br_exmem", ctrl, C_NORM);
`else
    chk("br_exmem", ctrl, C_STALL);
`endif
    ex_mem_regwrite = 0; id_ex_rt = 4'd0; if_id_rs = 4'd0; id_ex_regwrite = 1; #1;
    chk("br_r0", ctrl, C_STALL);
    id_ex_regwrite = 0; #1;
    chk("br_r0_nowr", ctrl, C_NORM);
    idle();

    // Taken branches and jump
    id_opcode = 4'd5; br_lt = 1; #1;
    chk("blt_taken", ctrl, C_TAKEN);
    id_opcode = 4'd4; br_lt = 0; br_eq = 0; #1;
    chk("bgt_taken", ctrl, C_TAKEN);
    br_eq = 1; #1;
    chk("bgt_not", ctrl, C_NORM);
    id_opcode = 4'd6; #1;
    chk("beq_taken", ctrl, C_TAKEN);
    id_opcode = 4'd7; br_eq = 0; #1;
    chk("j_taken", ctrl, C_TAKEN);
    idle();

    // Reset asserted in the middle of LD_WAIT
    tick();
    id_ex_memread = 1; id_ex_rt = 4'd4; if_id_rt = 4'd4;
    tick(); id_ex_memread = 0; #1;
    chk("ldw_pre", ctrl, C_STALL);
    #2 rst_n = 1'b0; #1;
    chk("ldw_rst_ctrl", ctrl, C_RST);
    chk("ldw_rst_exc", {3'b0, exc}, 7'b0);
    tick(); #2 rst_n = 1'b1;
    idle();
    tick();
    chk("post_rst", ctrl, C_NORM);
    tick();
    chk("post_rst2", ctrl, C_NORM);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
